// File: rtl/layer_scheduler.sv
// Runs one shared neuron MAC engine over every neuron of a fully-connected layer.
// Each result is requantized (shift, optional ReLU, saturate) into its own output slot.
module layer_scheduler #(
  parameter int OUT_SIZE  = 10,
  parameter int WIDTH_OUT = 32,
  parameter int WIDTH_Q   = 8,
  parameter int SHIFT     = 8,
  parameter int RELU      = 1,
  localparam int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        layer_go,
  output logic                        layer_busy,
  output logic                        layer_done,
  output logic                        neuron_go,
  input  logic                        neuron_done,
  input  logic signed [WIDTH_OUT-1:0] neuron_out,
  output logic [IDX_W-1:0]            neuron_idx,
  output logic [WIDTH_Q*OUT_SIZE-1:0] layer_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);
  localparam logic signed [WIDTH_OUT-1:0] QMAX = WIDTH_OUT'((2 ** (WIDTH_Q - 1)) - 1);
  localparam logic signed [WIDTH_OUT-1:0] QMIN = WIDTH_OUT'(-(2 ** (WIDTH_Q - 1)));

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [WIDTH_Q*OUT_SIZE-1:0] out_q, out_d;
  logic [WIDTH_Q-1:0]          quant;

  // The low WIDTH_Q bits of QMAX/QMIN are exactly the saturated codes, so one slice serves all cases.
  function automatic logic [WIDTH_Q-1:0] requant(input logic signed [WIDTH_OUT-1:0] x);
    logic signed [WIDTH_OUT-1:0] s;
    s = x >>> SHIFT;
    if (RELU != 0 && s[WIDTH_OUT-1]) s = '0;
    if (s > QMAX)      s = QMAX;
    else if (s < QMIN) s = QMIN;
    return s[WIDTH_Q-1:0];
  endfunction

  assign quant = requant(neuron_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (layer_go) begin
          state_d = ISSUE;
          idx_d   = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (neuron_done) begin
          for (int k = 0; k < OUT_SIZE; k++) begin
            if (k == int'(idx_q)) out_d[k*WIDTH_Q +: WIDTH_Q] = quant;
          end
          // The index only advances here, so it is stable from ISSUE through the capture.
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign layer_busy = (state_q != IDLE);
  assign neuron_go  = (state_q == ISSUE);
  assign layer_done = (state_q == DONE);
  assign neuron_idx = idx_q;
  assign layer_out  = out_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: a 4-neuron layer plus two single-neuron
// instances (ReLU on/off), each driven by a fixed-latency mock neuron.
module tb_layer_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-neuron instance, mock latency 5, result 256*(idx+1) (negated in negMode)
  logic        go4 = 1'b0, spur4 = 1'b0, negMode = 1'b0;
  logic        busy4, done4, ngo4, ndone4;
  logic [1:0]  idx4;
  logic [31:0] nout4, lo4;
  int          cnt4;

  assign ndone4 = (cnt4 == 1) || spur4;
  assign nout4  = negMode ? -((32'(idx4) + 32'd1) << 8) : ((32'(idx4) + 32'd1) << 8);

  always @(posedge clk or posedge reset) begin
    if (reset)           cnt4 <= 0;
    else if (ngo4)       cnt4 <= 5;
    else if (cnt4 != 0)  cnt4 <= cnt4 - 1;
  end

  layer_scheduler #(.OUT_SIZE(4), .WIDTH_OUT(32), .WIDTH_Q(8), .SHIFT(8), .RELU(1)) u4 (
    .clk(clk), .reset(reset), .layer_go(go4), .layer_busy(busy4), .layer_done(done4),
    .neuron_go(ngo4), .neuron_done(ndone4), .neuron_out(nout4), .neuron_idx(idx4),
    .layer_out(lo4));

  // single-neuron instances, mock latency 1, result taken from valR / valN
  logic        goR = 1'b0, goN = 1'b0;
  logic        busyR, doneR, ngoR, ndoneR, busyN, doneN, ngoN, ndoneN;
  logic [0:0]  idxR, idxN;
  logic [31:0] valR = '0, valN = '0;
  logic [7:0]  loR, loN;
  int          cntR, cntN;

  assign ndoneR = (cntR == 1);
  assign ndoneN = (cntN == 1);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cntR <= 0;
      cntN <= 0;
    end else begin
      cntR <= ngoR ? 1 : 0;
      cntN <= ngoN ? 1 : 0;
    end
  end

  layer_scheduler #(.OUT_SIZE(1), .WIDTH_OUT(32), .WIDTH_Q(8), .SHIFT(8), .RELU(1)) u1r (
    .clk(clk), .reset(reset), .layer_go(goR), .layer_busy(busyR), .layer_done(doneR),
    .neuron_go(ngoR), .neuron_done(ndoneR), .neuron_out(valR), .neuron_idx(idxR),
    .layer_out(loR));

  layer_scheduler #(.OUT_SIZE(1), .WIDTH_OUT(32), .WIDTH_Q(8), .SHIFT(8), .RELU(0)) u1n (
    .clk(clk), .reset(reset), .layer_go(goN), .layer_busy(busyN), .layer_done(doneN),
    .neuron_go(ngoN), .neuron_done(ndoneN), .neuron_out(valN), .neuron_idx(idxN),
    .layer_out(loN));

  // Observers sampled mid-cycle: index at each neuron_go, go/done overlap, single-neuron index
  logic [1:0] idxLog4[$];
  bit         overlap4 = 1'b0;
  bit         idxBad1 = 1'b0;

  always @(negedge clk) begin
    if (ngo4) idxLog4.push_back(idx4);
    if (ngo4 && done4) overlap4 = 1'b1;
    if (idxR !== 1'b0) idxBad1 = 1'b1;
  end

  // Starts a layer on u4 from an IDLE cycle; returns cycles from go to done (-1 on timeout)
  // and leaves the caller one cycle past layer_done.
  task automatic runLayer4(output int lat);
    int start;
    lat = -1;
    go4 = 1'b1;
    start = cyc;
    @(posedge clk); #1 go4 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done4) begin
        lat = cyc - start;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic runSingle(input bit useN, input logic [31:0] v, output int lat);
    int start;
    lat = -1;
    if (useN) begin valN = v; goN = 1'b1; end
    else      begin valR = v; goR = 1'b1; end
    start = cyc;
    @(posedge clk); #1 goN = 1'b0; goR = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (useN ? doneN : doneR) begin
        lat = cyc - start;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done4); end
    total++; if (ngo4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ngo got=%b want=0", ngo4); end
    total++; if (idx4 !== 2'd0) begin bad++; $display("[TB] FAIL reset_idx got=%0d want=0", idx4); end
    total++; if (lo4 !== 32'h0) begin bad++; $display("[TB] FAIL reset_slots got=%h want=0", lo4); end
    total++; if (loN !== 8'h0) begin bad++; $display("[TB] FAIL reset_slotN got=%h want=0", loN); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_layer;
    int lat;
    idxLog4.delete();
    overlap4 = 1'b0;
    runLayer4(lat);
    total++; if (lat !== 25) begin bad++; $display("[TB] FAIL layer_latency got=%0d want=25", lat); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (lo4[k*8 +: 8] !== 8'(k + 1)) begin
        bad++; $display("[TB] FAIL slot%0d got=%0d want=%0d", k, lo4[k*8 +: 8], k + 1);
      end
    end
    total++; if (idxLog4.size() != 4) begin bad++; $display("[TB] FAIL go_count got=%0d want=4", idxLog4.size()); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL busy_after got=%b want=0", busy4); end
    total++; if (overlap4 !== 1'b0) begin bad++; $display("[TB] FAIL go_done_overlap got=%b want=0", overlap4); end
  endtask

  task automatic test_saturation;
    logic [31:0] vr[4] = '{32'h00010000, 32'hFFFFFF00, 32'h00007FFF, 32'h000000FF};
    logic [7:0]  er[4] = '{8'd127, 8'd0, 8'd127, 8'd0};
    logic [31:0] vn[2] = '{32'hFFFF0000, 32'hFFFFFF00};
    logic [7:0]  en[2] = '{8'h80, 8'hFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      runSingle(1'b0, vr[i], lat);
      total++;
      if (loR !== er[i]) begin bad++; $display("[TB] FAIL relu_sat%0d got=%h want=%h", i, loR, er[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      runSingle(1'b1, vn[i], lat);
      total++;
      if (loN !== en[i]) begin bad++; $display("[TB] FAIL signed_sat%0d got=%h want=%h", i, loN, en[i]); end
    end
  endtask

  task automatic test_ignored_inputs;
    int start, lat;
    bit restarted;
    idxLog4.delete();
    lat = -1;
    restarted = 1'b0;
    go4 = 1'b1;
    start = cyc;
    @(posedge clk); #1 go4 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      spur4 = ngo4;
      go4 = ((cyc - start) == 10);
      if (done4) begin
        lat = cyc - start;
        break;
      end
      @(posedge clk); #1;
    end
    spur4 = 1'b0;
    go4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (busy4) restarted = 1'b1;
    end
    total++; if (lat !== 25) begin bad++; $display("[TB] FAIL ignored_latency got=%0d want=25", lat); end
    total++; if (restarted) begin bad++; $display("[TB] FAIL no_restart got=busy want=idle"); end
    total++;
    if (idxLog4.size() != 4 || idxLog4[0] !== 2'd0 || idxLog4[1] !== 2'd1 ||
        idxLog4[2] !== 2'd2 || idxLog4[3] !== 2'd3) begin
      bad++; $display("[TB] FAIL idx_sequence got=%p want=0,1,2,3", idxLog4);
    end
    total++; if (lo4 !== 32'h04030201) begin bad++; $display("[TB] FAIL slots_unchanged got=%h want=04030201", lo4); end
  endtask

  task automatic test_reset_mid_layer;
    int lat;
    bit found;
    found = 1'b0;
    go4 = 1'b1;
    @(posedge clk); #1 go4 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (idx4 == 2'd2 && busy4 && !ngo4) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL reach_wait_idx2 got=timeout want=found"); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy4, done4, ngo4, idx4} !== 5'b0 || lo4 !== 32'h0) begin
      bad++; $display("[TB] FAIL async_reset got=%b%b%b idx=%0d slots=%h want=all zero",
                      busy4, done4, ngo4, idx4, lo4);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    idxLog4.delete();
    runLayer4(lat);
    total++; if (lat !== 25) begin bad++; $display("[TB] FAIL rerun_latency got=%0d want=25", lat); end
    total++; if (lo4 !== 32'h04030201) begin bad++; $display("[TB] FAIL rerun_slots got=%h want=04030201", lo4); end
    total++;
    if (idxLog4.size() != 4 || idxLog4[0] !== 2'd0) begin
      bad++; $display("[TB] FAIL rerun_start got=%p want=0,1,2,3", idxLog4);
    end
  endtask

  task automatic test_one_neuron;
    int lat;
    idxBad1 = 1'b0;
    runSingle(1'b0, 32'h00000300, lat);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL one_latency got=%0d want=3", lat); end
    total++; if (loR !== 8'd3) begin bad++; $display("[TB] FAIL one_slot got=%0d want=3", loR); end
    total++; if (idxBad1) begin bad++; $display("[TB] FAIL one_idx got=nonzero want=0"); end
  endtask

  task automatic test_back_to_back;
    int start, lat;
    bit seen;
    runLayer4(lat);
    total++; if (lo4 !== 32'h04030201) begin bad++; $display("[TB] FAIL b2b_first got=%h want=04030201", lo4); end
    negMode = 1'b1;
    go4 = 1'b1;
    start = cyc;
    @(posedge clk); #1 go4 = 1'b0;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (!seen && idx4 == 2'd1) begin
        seen = 1'b1;
        total++;
        if (lo4 !== 32'h04030200) begin bad++; $display("[TB] FAIL b2b_partial got=%h want=04030200", lo4); end
      end
      if (done4) begin
        lat = cyc - start;
        break;
      end
      @(posedge clk); #1;
    end
    total++; if (lat !== 25) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=25", lat); end
    total++; if (lo4 !== 32'h0) begin bad++; $display("[TB] FAIL b2b_relu_slots got=%h want=0", lo4); end
    negMode = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_saturation();
    test_ignored_inputs();
    test_reset_mid_layer();
    test_one_neuron();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
